// File: rtl/debounced_input_ctrl.sv
// Purpose : memory-mapped input page; syncs/debounces 10 switches + 3 active-low buttons,
//           tracks last-pressed button, sticky press flags and per-button 8-bit press counts.
// Latency : reads return one cycle after read_enable; pin change visible in stable state
//           DEBOUNCE_CYCLES+2 edges after first sample.
// Backpressure: none; CPU strobes are accepted every cycle.
// Ports   : clock, reset (sync, active-high); addr/read_enable/write_enable/datain = CPU
//           side; io_in = raw pins ([12:10] buttons, [9:0] switches); dataout = registered
//           read data; irq = any sticky press flag set.
module debounced_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  addr,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] datain,
  input  logic [12:0] io_in,
  output logic [31:0] dataout,
  output logic        irq
);

  // Buttons idle high (released), switches idle low.
  localparam logic [12:0]      IO_RST   = 13'h1C00;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [12:0]      sync_q1;
  logic [12:0]      sync_q2;
  logic [12:0]      stable;
  logic [CNT_W-1:0] db_cnt [13];
  logic [12:0]      flip;

  logic [1:0]       operator;
  logic [1:0]       operator_next;
  logic [2:0]       flags;
  logic [2:0]       flags_next;
  logic [2:0]       press;
  logic [2:0]       flag_clr;
  logic [2:0]       cnt_clr;
  logic [7:0]       press_cnt [3];
  logic [31:0]      rd_data;

  // A bit flips on the edge where its mismatch run reaches DEBOUNCE_CYCLES.
  always_comb begin
    for (int i = 0; i < 13; i++) begin
      flip[i] = (sync_q2[i] != stable[i]) && (db_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1 <= IO_RST;
      sync_q2 <= IO_RST;
      stable  <= IO_RST;
      for (int i = 0; i < 13; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_q1 <= io_in;
      sync_q2 <= sync_q1;
      stable  <= stable ^ flip;
      for (int i = 0; i < 13; i++) begin
        if (sync_q2[i] == stable[i] || flip[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press event fires on the same edge the stable button bit falls 1->0, so the
  // flag/counter/operator update lands together with the debounced value.
  assign press = stable[12:10] & flip[12:10];

  always_comb begin
    operator_next = operator;
    if (press[0]) begin
      operator_next = 2'd0;
    end else if (press[1]) begin
      operator_next = 2'd1;
    end else if (press[2]) begin
      operator_next = 2'd2;
    end
  end

  always_comb begin
    flag_clr = 3'b000;
    cnt_clr  = 3'b000;
    if (read_enable && addr == 5'd3) begin
      flag_clr = 3'b111;
    end
    if (write_enable && addr == 5'd3) begin
      flag_clr = flag_clr | datain[2:0];
    end
    if (write_enable && addr == 5'd4) begin
      cnt_clr = datain[2:0];
    end
    // Set wins over a same-cycle clear.
    flags_next = (flags & ~flag_clr) | press;
  end

  // Read mux sees pre-update register values, so read-to-clear returns the old flags.
  always_comb begin
    rd_data = 32'h0;
    case (addr)
      5'd0:    rd_data = {27'b0, stable[4:0]};
      5'd1:    rd_data = {27'b0, stable[9:5]};
      5'd2:    rd_data = {30'b0, operator};
      5'd3:    rd_data = {29'b0, flags};
      5'd4:    rd_data = {8'b0, press_cnt[2], press_cnt[1], press_cnt[0]};
      5'd5:    rd_data = {29'b0, ~stable[12:10]};
      default: rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      operator <= 2'b00;
      flags    <= 3'b000;
      dataout  <= 32'h0;
      for (int j = 0; j < 3; j++) begin
        press_cnt[j] <= 8'h00;
      end
    end else begin
      operator <= operator_next;
      flags    <= flags_next;
      if (read_enable) begin
        dataout <= rd_data;
      end
      for (int j = 0; j < 3; j++) begin
        // Clear plus increment in one cycle leaves a count of 1.
        if (cnt_clr[j]) begin
          press_cnt[j] <= {7'b0, press[j]};
        end else begin
          press_cnt[j] <= press_cnt[j] + {7'b0, press[j]};
        end
      end
    end
  end

  assign irq = |flags;

endmodule

// File: tb/tb_debounced_input_ctrl.sv
module tb_debounced_input_ctrl;

  localparam int DB = 4;

  logic        clock;
  logic        reset;
  logic [4:0]  addr;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] datain;
  logic [12:0] io_in;
  logic [31:0] dataout;
  logic        irq;

  int errors = 0;
  int checks = 0;
  bit mon_on = 0;

  debounced_input_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .addr(addr), .read_enable(read_enable),
    .write_enable(write_enable), .datain(datain), .io_in(io_in),
    .dataout(dataout), .irq(irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: a pin stable value flips once the last DB synchronised
  // samples (pins delayed two edges) all disagree with it.
  logic [12:0] m_pin [DB+1];
  logic [12:0] m_stable;
  logic [1:0]  m_op;
  logic [2:0]  m_flags;
  int          m_cnt [3];
  logic [31:0] m_dout;

  function automatic logic [31:0] m_map(input logic [4:0] a);
    case (a)
      5'd0: return {27'b0, m_stable[4:0]};
      5'd1: return {27'b0, m_stable[9:5]};
      5'd2: return {30'b0, m_op};
      5'd3: return {29'b0, m_flags};
      5'd4: return {8'b0, 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
      5'd5: return {29'b0, ~m_stable[12:10]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clock) begin
    logic [12:0] fl;
    logic [2:0]  ev;
    logic [2:0]  clr;
    if (reset) begin
      for (int k = 0; k <= DB; k++) m_pin[k] = 13'h1C00;
      m_stable = 13'h1C00;
      m_op     = 2'b00;
      m_flags  = 3'b000;
      for (int j = 0; j < 3; j++) m_cnt[j] = 0;
      m_dout   = 32'h0;
    end else begin
      if (read_enable) m_dout = m_map(addr);
      for (int b = 0; b < 13; b++) begin
        fl[b] = 1'b1;
        for (int k = 1; k <= DB; k++) begin
          if (m_pin[k][b] == m_stable[b]) fl[b] = 1'b0;
        end
      end
      ev = m_stable[12:10] & fl[12:10];
      if (ev[0]) m_op = 2'd0;
      else if (ev[1]) m_op = 2'd1;
      else if (ev[2]) m_op = 2'd2;
      clr = 3'b000;
      if (read_enable && addr == 5'd3) clr = 3'b111;
      if (write_enable && addr == 5'd3) clr = clr | datain[2:0];
      m_flags = (m_flags & ~clr) | ev;
      for (int j = 0; j < 3; j++) begin
        if (write_enable && addr == 5'd4 && datain[j]) m_cnt[j] = ev[j] ? 1 : 0;
        else if (ev[j]) m_cnt[j] = (m_cnt[j] + 1) % 256;
      end
      m_stable = m_stable ^ fl;
      for (int k = DB; k >= 1; k--) m_pin[k] = m_pin[k-1];
      m_pin[0] = io_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      chk("model_dataout", dataout, m_dout);
      chk("model_irq", {31'b0, irq}, {31'b0, |m_flags});
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] d);
    read_enable = 1'b1;
    addr = a;
    tick();
    read_enable = 1'b0;
    d = dataout;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    write_enable = 1'b1;
    addr = a;
    datain = d;
    tick();
    write_enable = 1'b0;
  endtask

  typedef struct {
    logic [12:0] io;
    int          settle;
    logic [4:0]  a;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t rst_tab [6];
  vec_t pri_tab [5];

  initial begin
    logic [31:0] d;

    rst_tab[0] = '{13'h1C00, 0, 5'd0, 32'h0, "rst_a0"};
    rst_tab[1] = '{13'h1C00, 0, 5'd1, 32'h0, "rst_a1"};
    rst_tab[2] = '{13'h1C00, 0, 5'd2, 32'h0, "rst_a2"};
    rst_tab[3] = '{13'h1C00, 0, 5'd3, 32'h0, "rst_a3"};
    rst_tab[4] = '{13'h1C00, 0, 5'd4, 32'h0, "rst_a4"};
    rst_tab[5] = '{13'h1C00, 0, 5'd5, 32'h0, "rst_a5"};
    // Buttons 0 and 2 pressed together, switches at 0x15.
    pri_tab[0] = '{13'h0815, 8, 5'd2, 32'h0,      "pri_operator"};
    pri_tab[1] = '{13'h0815, 0, 5'd4, 32'h010001, "pri_counts"};
    pri_tab[2] = '{13'h0815, 0, 5'd5, 32'h5,      "pri_held"};
    pri_tab[3] = '{13'h0815, 0, 5'd3, 32'h5,      "pri_flags"};
    pri_tab[4] = '{13'h0815, 0, 5'd3, 32'h0,      "pri_flags_cleared"};

    reset = 1'b1; addr = 5'd0; read_enable = 1'b0; write_enable = 1'b0;
    datain = 32'h0; io_in = 13'h1C00;
    tick();
    mon_on = 1'b1;
    tick();
    reset = 1'b0;

    chk("rst_irq", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      io_in = rst_tab[i].io;
      ticks(rst_tab[i].settle);
      do_read(rst_tab[i].a, d);
      chk(rst_tab[i].name, d, rst_tab[i].exp);
    end

    // Switch debounce: change sampled at edge 1, stable at edge 6.
    io_in = 13'h1C15;
    ticks(5);
    read_enable = 1'b1; addr = 5'd0;
    tick();
    chk("sw_edge6", dataout, 32'h0);
    tick();
    chk("sw_edge7", dataout, 32'h15);
    read_enable = 1'b0;

    // Glitch of 3 cycles on button 0 must be rejected.
    io_in = 13'h1815;
    ticks(3);
    io_in = 13'h1C15;
    ticks(8);
    do_read(5'd3, d); chk("glitch_flags", d, 32'h0);
    do_read(5'd4, d); chk("glitch_cnt", d, 32'h0);
    chk("glitch_irq", {31'b0, irq}, 32'h0);

    // Simultaneous press of buttons 0 and 2.
    io_in = 13'h0815;
    ticks(8);
    chk("pri_irq_set", {31'b0, irq}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      io_in = pri_tab[i].io;
      ticks(pri_tab[i].settle);
      do_read(pri_tab[i].a, d);
      chk(pri_tab[i].name, d, pri_tab[i].exp);
    end
    chk("pri_irq_clear", {31'b0, irq}, 32'h0);
    io_in = 13'h1C15;
    ticks(8);

    // Button 1 event on the same edge as a read-to-clear of addr 3.
    io_in = 13'h1415;
    ticks(5);
    read_enable = 1'b1; addr = 5'd3;
    tick();
    read_enable = 1'b0;
    chk("race_read_old", dataout, 32'h0);
    chk("race_irq", {31'b0, irq}, 32'h1);
    do_read(5'd3, d); chk("race_flag1_kept", d, 32'h2);
    do_read(5'd2, d); chk("race_operator", d, 32'h1);
    io_in = 13'h1C15;
    ticks(8);

    // Counter clear, 256-press wrap, then clear coincident with a press.
    do_write(5'd4, 32'h2);
    do_read(5'd4, d); chk("cnt_after_clear", d, 32'h010001);
    for (int p = 0; p < 256; p++) begin
      io_in = 13'h1415; ticks(7);
      io_in = 13'h1C15; ticks(7);
    end
    do_read(5'd4, d); chk("cnt_wrap", d, 32'h010001);
    io_in = 13'h1415;
    ticks(5);
    do_write(5'd4, 32'h2);
    do_read(5'd4, d); chk("cnt_clear_vs_inc", d, 32'h010101);
    io_in = 13'h1C15;
    ticks(8);

    // Reset mid-press: held button produces one event DB+2 edges after release.
    io_in = 13'h1815;
    ticks(3);
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    chk("rst_mid_irq0", {31'b0, irq}, 32'h0);
    ticks(DB + 1);
    chk("rst_mid_before", {31'b0, irq}, 32'h0);
    tick();
    chk("rst_mid_event", {31'b0, irq}, 32'h1);
    do_read(5'd3, d); chk("rst_mid_flags", d, 32'h1);
    do_read(5'd4, d); chk("rst_mid_cnt", d, 32'h000001);
    io_in = 13'h1C15;
    ticks(8);

    // Randomised traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0) io_in = 13'($urandom);
      read_enable  = 1'($urandom_range(1));
      write_enable = ($urandom_range(3) == 0);
      addr         = 5'($urandom_range(7));
      datain       = $urandom;
      reset        = ($urandom_range(499) == 0);
      tick();
    end
    reset = 1'b0; read_enable = 1'b0; write_enable = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
